// File: rtl/pipeline_rr_scheduler.sv
// Round-robin front end for a fixed-latency, non-stallable datapath: grants one
// requester per cycle, tags the item, and steers each result back to its owner.
module pipeline_rr_scheduler #(
    parameter int BIT_WIDTH        = 10,
    parameter int NUMBER_OF_STAGES = 5,
    parameter int NUM_REQ          = 4,
    parameter int ID_WIDTH         = 2,
    parameter int CNT_WIDTH        = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]            req_mask,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [BIT_WIDTH-1:0]          pipe_in,
    input  logic [BIT_WIDTH-1:0]          pipe_out,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [BIT_WIDTH-1:0]          resp_data,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic [CNT_WIDTH-1:0]          inflight
);

    localparam int SUM_W = ID_WIDTH + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    grant_allow;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic [ID_WIDTH-1:0]     offset;
    logic                    grant_any;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      rotated;
    logic [2*NUM_REQ-1:0]    elig_dbl;
    logic [SUM_W-1:0]        winner_sum;
    logic [NUMBER_OF_STAGES-1:0] tag_valid;
    logic [ID_WIDTH-1:0]     tag_id [NUMBER_OF_STAGES];
    logic                    tail_valid;
    logic [ID_WIDTH-1:0]     tail_id;

    // State register; drain_done is the registered image of HALTED.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            state      <= state_next;
            drain_done <= (state_next == HALTED);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN: begin
                if (!drain_req)                              state_next = RUN;
                else if (inflight == '0 && !tail_valid)      state_next = HALTED;
            end
            HALTED:  if (!drain_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Grants are also held off while reset is asserted so no request is
    // consumed by a scheduler that is being cleared.
    always_comb begin
        grant_allow = (state == RUN) && reset_n;
    end

    // Handshake: req_grant[r] is high in the same cycle as req_valid[r]; the
    // requester treats its current data as consumed at that clock edge.
    always_comb begin
        eligible   = req_valid & req_mask & {NUM_REQ{grant_allow}};
        elig_dbl   = {eligible, eligible} >> rr_ptr;
        rotated    = elig_dbl[NUM_REQ-1:0];
        grant_any  = |rotated;
        offset     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = ID_WIDTH'(i);
        end
        winner_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (winner_sum >= SUM_W'(NUM_REQ)) winner_sum = winner_sum - SUM_W'(NUM_REQ);
        grant_idx  = winner_sum[ID_WIDTH-1:0];
    end

    always_comb begin
        req_grant = '0;
        pipe_in   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_any && grant_idx == ID_WIDTH'(r)) begin
                req_grant[r] = 1'b1;
                pipe_in      = req_data[r*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
        end
    end

    // Tag shift register has the datapath's depth, so its tail is aligned with pipe_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            for (int s = 0; s < NUMBER_OF_STAGES; s++) tag_id[s] <= '0;
        end else begin
            tag_valid[0] <= grant_any;
            tag_id[0]    <= grant_any ? grant_idx : '0;
            for (int s = 1; s < NUMBER_OF_STAGES; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    always_comb begin
        tail_valid = tag_valid[NUMBER_OF_STAGES-1];
        tail_id    = tag_id[NUMBER_OF_STAGES-1];
        resp_valid = '0;
        resp_id    = tail_valid ? tail_id : '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (tail_valid && tail_id == ID_WIDTH'(r)) resp_valid[r] = 1'b1;
        end
    end

    assign resp_data = pipe_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({grant_any, tail_valid})
                2'b10:   inflight <= inflight + CNT_WIDTH'(1);
                2'b01:   inflight <= inflight - CNT_WIDTH'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_rr_scheduler.sv
// Bench for pipeline_rr_scheduler: behavioural datapath, queue-based reference
// model of the scheduler, and one task per scenario.
module tb_pipeline_rr_scheduler;

    localparam int BW  = 10;
    localparam int NS  = 5;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int CW  = 3;
    localparam int OW  = 2*NR + 2*BW + IDW + CW + 1;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    logic               clk;
    logic               reset_n;
    logic [NR-1:0]      req_valid;
    logic [NR*BW-1:0]   req_data;
    logic [NR-1:0]      req_mask;
    logic [NR-1:0]      req_grant;
    logic [BW-1:0]      pipe_in;
    logic [BW-1:0]      pipe_out;
    logic [NR-1:0]      resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [BW-1:0]      resp_data;
    logic               drain_req;
    logic               drain_done;
    logic [CW-1:0]      inflight;

    pipeline_rr_scheduler #(
        .BIT_WIDTH(BW), .NUMBER_OF_STAGES(NS), .NUM_REQ(NR), .ID_WIDTH(IDW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_mask(req_mask), .req_grant(req_grant), .pipe_in(pipe_in), .pipe_out(pipe_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight)
    );

    // Behavioural datapath: plain delay line that clears on reset.
    logic [BW-1:0] dp [NS];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NS; s++) dp[s] <= '0;
        end else begin
            dp[0] <= pipe_in;
            for (int s = 1; s < NS; s++) dp[s] <= dp[s-1];
        end
    end
    assign pipe_out = dp[NS-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an item is granted with a due cycle and returns exactly then.
    typedef struct {
        int            due;
        int            id;
        logic [BW-1:0] data;
    } ent_t;

    ent_t           m_q[$];
    int             m_rr;
    int             m_state;
    int             m_cyc;
    int             exp_g;
    logic [OW-1:0]  exp_vec;
    logic [IDW-1:0] exp_q[$];

    int vectors;
    int miscompares;

    function automatic logic [OW-1:0] act_vec();
        return {req_grant, pipe_in, resp_valid, resp_id, resp_data, inflight, drain_done};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_rr    = 0;
        m_state = M_RUN;
    endfunction

    function automatic void model_eval();
        logic [NR-1:0]  g_oh;
        logic [BW-1:0]  g_data;
        logic [NR-1:0]  rv;
        logic [IDW-1:0] rid;
        logic [BW-1:0]  rdata;
        g_oh = '0; g_data = '0; rv = '0; rid = '0; rdata = '0;
        exp_g = -1;
        if (m_state == M_RUN && reset_n) begin
            for (int k = 0; k < NR; k++) begin
                int r;
                r = (m_rr + k) % NR;
                if (exp_g < 0 && req_valid[r] && req_mask[r]) exp_g = r;
            end
        end
        if (exp_g >= 0) begin
            g_oh[exp_g] = 1'b1;
            g_data      = req_data[exp_g*BW +: BW];
        end
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            rv[m_q[0].id] = 1'b1;
            rid           = IDW'(m_q[0].id);
            rdata         = m_q[0].data;
        end
        exp_vec = {g_oh, g_data, rv, rid, rdata, CW'(m_q.size()), (m_state == M_HALTED)};
    endfunction

    task automatic tick_eval();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick_commit();
        int nxt;
        @(posedge clk);
        if (reset_n) begin
            nxt = m_state;
            case (m_state)
                M_RUN:   nxt = drain_req ? M_DRAIN : M_RUN;
                M_DRAIN: nxt = !drain_req ? M_RUN : (m_q.size() == 0 ? M_HALTED : M_DRAIN);
                default: nxt = drain_req ? M_HALTED : M_RUN;
            endcase
            if (m_q.size() > 0 && m_q[0].due == m_cyc) void'(m_q.pop_front());
            if (exp_g >= 0) begin
                m_q.push_back('{due: m_cyc + NS, id: exp_g, data: req_data[exp_g*BW +: BW]});
                m_rr = (exp_g + 1) % NR;
            end
            m_state = nxt;
        end
        m_cyc++;
        #1;
    endtask

    task automatic rand_data();
        for (int r = 0; r < NR; r++) req_data[r*BW +: BW] = BW'($urandom_range(0, 1023));
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            tick_eval();
            tick_commit();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; req_valid = '0; req_mask = '1; drain_req = 1'b0; req_data = '0;
        #2 reset_n = 1'b0;
        req_valid = '1;
        #1;
        model_reset();
        vectors++;
        if (act_vec() !== {OW{1'b0}}) begin
            miscompares++;
            $display("FAIL reset_hold actual=%h expected=%h", act_vec(), {OW{1'b0}});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        req_valid = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d actual=%h expected=%h", m_cyc, act_vec(), exp_vec);
            end
            tick_commit();
        end
    endtask

    task automatic test_single();
        rand_data();
        req_data[2*BW +: BW] = 10'h155;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c == 0) ? 4'b0100 : 4'b0000;
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL single cyc=%0d actual=%h expected=%h", m_cyc, act_vec(), exp_vec);
            end
            if (c == 0) begin
                vectors++;
                if ({req_grant, pipe_in} !== {4'b0100, 10'h155}) begin
                    miscompares++;
                    $display("FAIL single_grant actual=%b/%h expected=0100/155", req_grant, pipe_in);
                end
            end
            if (c == 5) begin
                vectors++;
                if ({resp_valid, resp_id, resp_data, inflight} !== {4'b0100, 2'd2, 10'h155, 3'd1}) begin
                    miscompares++;
                    $display("FAIL single_resp actual=%b/%0d/%h/%0d expected=0100/2/155/1",
                             resp_valid, resp_id, resp_data, inflight);
                end
            end
            tick_commit();
        end
    endtask

    task automatic test_full();
        int start;
        start = m_rr;
        exp_q.delete();
        req_mask = '1;
        for (int c = 0; c < 18; c++) begin
            req_valid = (c < 12) ? 4'b1111 : 4'b0000;
            rand_data();
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL full cyc=%0d actual=%h expected=%h", m_cyc, act_vec(), exp_vec);
            end
            if (c < 12) begin
                vectors++;
                if (req_grant !== NR'(1 << ((start + c) % NR))) begin
                    miscompares++;
                    $display("FAIL full_order c=%0d actual=%b expected_id=%0d", c, req_grant, (start + c) % NR);
                end
                exp_q.push_back(IDW'((start + c) % NR));
            end
            if (c >= NS && c < NS + 12) begin
                logic [IDW-1:0] want;
                want = exp_q.pop_front();
                vectors++;
                if (resp_id !== want || resp_valid !== NR'(1 << want)) begin
                    miscompares++;
                    $display("FAIL full_resp c=%0d actual=%0d/%b expected=%0d", c, resp_id, resp_valid, want);
                end
            end
            if (c >= NS && c < 12) begin
                vectors++;
                if (inflight !== CW'(NS)) begin
                    miscompares++;
                    $display("FAIL full_inflight c=%0d actual=%0d expected=%0d", c, inflight, NS);
                end
            end
            tick_commit();
        end
    endtask

    task automatic test_wrap();
        logic [NR-1:0] vt [7];
        logic [NR-1:0] gt [7];
        vt = '{4'b0100, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        gt = '{4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        for (int c = 0; c < 7; c++) begin
            req_valid = vt[c];
            rand_data();
            tick_eval();
            vectors++;
            if (req_grant !== gt[c] || act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL wrap c=%0d grant=%b want=%b actual=%h expected=%h",
                         c, req_grant, gt[c], act_vec(), exp_vec);
            end
            tick_commit();
        end
        idle(NS + 1);
    endtask

    task automatic test_mask();
        logic [NR-1:0] prev;
        prev = '0;
        req_mask = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            req_valid = 4'b1111;
            rand_data();
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec || !(req_grant inside {4'b0010, 4'b1000}) || req_grant === prev) begin
                miscompares++;
                $display("FAIL mask c=%0d grant=%b prev=%b actual=%h expected=%h",
                         c, req_grant, prev, act_vec(), exp_vec);
            end
            prev = req_grant;
            tick_commit();
        end
        req_mask = '1;
        idle(NS + 1);
    endtask

    task automatic test_drain();
        bit seen;
        seen = 1'b0;
        req_mask = '1;
        for (int c = 0; c < 3; c++) begin
            req_valid = '1; rand_data();
            tick_eval(); tick_commit();
        end
        drain_req = 1'b1;
        tick_eval();
        vectors++;
        if (req_grant === '0 || act_vec() !== exp_vec) begin
            miscompares++;
            $display("FAIL drain_edge_grant actual=%h expected=%h", act_vec(), exp_vec);
        end
        tick_commit();
        for (int c = 0; c < 20 && !seen; c++) begin
            rand_data();
            tick_eval();
            vectors++;
            if (req_grant !== '0 || act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL drain_block c=%0d actual=%h expected=%h", c, act_vec(), exp_vec);
            end
            if (drain_done) begin
                seen = 1'b1;
                vectors++;
                if (inflight !== '0 || resp_valid !== '0) begin
                    miscompares++;
                    $display("FAIL drain_empty actual=%0d/%b expected=0/0000", inflight, resp_valid);
                end
            end
            tick_commit();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL drain_timeout actual=drain_done_low expected=drain_done_high");
        end
        drain_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec || (c == 1 && req_grant === '0)) begin
                miscompares++;
                $display("FAIL drain_resume c=%0d actual=%h expected=%h", c, act_vec(), exp_vec);
            end
            tick_commit();
        end
        idle(NS + 1);
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            req_valid = '1; rand_data();
            tick_eval(); tick_commit();
        end
        vectors++;
        if (inflight !== CW'(3)) begin
            miscompares++;
            $display("FAIL midflight_count actual=%0d expected=3", inflight);
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({req_grant, resp_valid, inflight} !== {4'b0000, 4'b0000, 3'd0}) begin
            miscompares++;
            $display("FAIL midflight_reset actual=%b/%b/%0d expected=0000/0000/0", req_grant, resp_valid, inflight);
        end
        tick_eval(); tick_commit();
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 2) ? 4'b1111 : 4'b0000;
            rand_data();
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec || (c == 0 && req_grant !== 4'b0001) || (c < NS && resp_valid !== '0)) begin
                miscompares++;
                $display("FAIL midflight_after c=%0d actual=%h expected=%h", c, act_vec(), exp_vec);
            end
            tick_commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            req_mask  = ($urandom_range(0, 3) == 0) ? NR'($urandom_range(0, 15)) : '1;
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            rand_data();
            tick_eval();
            vectors++;
            if (act_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL random cyc=%0d actual=%h expected=%h", m_cyc, act_vec(), exp_vec);
            end
            tick_commit();
        end
        drain_req = 1'b0;
        req_mask  = '1;
        idle(NS + 2);
    endtask

    initial begin
        vectors = 0; miscompares = 0; m_cyc = 0; exp_g = -1;
        model_reset();
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_mask();
        test_drain();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
